buffer_arbiter: RTL and testbench
=================================

# buffer_arbiter

Arbitrates the single-port 4096-word sample buffer between two requesters: the host load/unload port and the tanh engine sequencer (write/read/Wg address stream). Sits between the engine controller's address/write-enable outputs and the buffer SRAM. Provides burst-limited round-robin sharing, engine priority while the engine is busy, registered SRAM drive, and read-return steering.

## Interface
- ADDR_W, 12, buffer address width
- DATA_W, 16, buffer word width
- MAX_BURST, 16, consecutive accepts before the owner must yield to a waiting requester (1..255)

- clock  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- host_req / host_we  in  1 each  host request; write when high, read when low
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle (combinational)
- host_rvalid  out  1  host read data valid on rdata
- engine_req / engine_we  in  1 each  engine request; write when high, read when low
- engine_addr  in  ADDR_W  engine address
- engine_wdata  in  DATA_W  engine write data
- engine_gnt  out  1  engine request accepted this cycle (combinational)
- engine_rvalid  out  1  engine read data valid on rdata
- engine_lock  in  1  engine BUSY; engine takes strict priority
- mem_en / mem_we  out  1 each  SRAM enable / write enable (registered)
- mem_addr  out  ADDR_W  SRAM address (registered)
- mem_wdata  out  DATA_W  SRAM write data (registered)
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en with mem_we low
- rdata  out  DATA_W  mem_rdata pass-through, shared by both requesters

## Operation
- FSM states: IDLE (no owner), HOST (host owns), ENG (engine owns). Also holds last_owner (1 bit) and burst_cnt (8 bits).
- Accept: a request is accepted when req and gnt are both high in the same cycle. At most one gnt is high per cycle. gnt is never high without the matching req.
- IDLE with one request: grant that request.
- IDLE with both requests: grant the requester that is not last_owner.
- Owner continues: the owner keeps the grant while its req stays high.
- Owner yields when any of these holds:
  - its req drops: go to IDLE, or to the other requester if that one is requesting;
  - burst_cnt reaches MAX_BURST while the other is requesting: switch owner.
- burst_cnt: resets to 1 on every owner change. Increments on each accept. Saturates at MAX_BURST while no competitor is waiting.
- engine_lock high:
  - engine_req always wins, regardless of state or burst_cnt; a host-owned burst is preempted in the same cycle;
  - host is granted only in cycles with engine_req low;
  - host starvation is permitted.
- Accepted request in cycle N:
  - cycle N+1: mem_en=1, with mem_we/mem_addr/mem_wdata taken from the winner;
  - cycle N+2, reads only: the winner's rvalid=1.
- Cycles with no accept: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their previous values.
- Read-return tag pipeline: two stages, {valid, owner}. It is independent of later grants, so back-to-back reads from alternating owners return in order.

## Timing
- Reset values: host_gnt=0, engine_gnt=0, host_rvalid=0, engine_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM=IDLE, last_owner=HOST (engine wins the first tie), burst_cnt=0.
- Reset mid-operation:
  - in-flight read tags are cleared; no rvalid appears after reset;
  - a write accepted in the cycle reset is asserted is discarded (mem_en=0 next cycle).
- Latency:
  - gnt: 0 cycles (same cycle as req);
  - write to SRAM: 1 cycle;
  - read data: 2 cycles.
- Throughput: one accept per cycle, including across owner switches (no dead cycle).
- Simultaneous owner req drop and competitor req: competitor is granted in that same cycle.
- rdata is meaningful only when the corresponding rvalid is high.

## Configuration
- ARB_STALL_CNT_EN defined:
  - adds output stall_cycles [15:0];
  - counts cycles in which host_req or engine_req is high and the corresponding gnt is low (at most +1 per cycle even when both stall);
  - saturates at 16'hFFFF;
  - cleared by reset.
- ARB_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then single host write: host_req=1, host_we=1, addr=12'h005, wdata=16'h1234 for one cycle -> host_gnt=1 same cycle; next cycle mem_en=1, mem_we=1, mem_addr=12'h005, mem_wdata=16'h1234.
- First tie after reset: both requesting reads -> engine granted first; engine_rvalid=1 exactly 2 cycles after accept, with rdata = SRAM model value.
- Burst limit, MAX_BURST=16, lock=0: host requests continuously and engine requests from cycle 0 while host owns -> host receives exactly 16 accepts, then engine is granted with no idle cycle; they alternate in 16-accept bursts.
- Lock preemption: host mid-burst (accept 3), engine_lock=1 and engine_req=1 -> engine_gnt=1 in that same cycle; host_gnt stays 0 until engine_req drops.
- Interleaved reads: alternating host/engine reads to addrs 1,2,3,4 -> rvalid pulses alternate host, engine, host, engine with the matching data; never both high in one cycle.
- Mid-read reset: reset asserted one cycle after an engine read is accepted -> engine_rvalid stays 0; with ARB_STALL_CNT_EN, stall_cycles reads 0 after reset.

Source files
------------

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: burst-limited round-robin sharing of the sample buffer SRAM between host and engine.
// Define ARB_STALL_CNT_EN to add the stall_cycles counter output.
module buffer_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  input  logic              engine_req,
  input  logic              engine_we,
  input  logic [ADDR_W-1:0] engine_addr,
  input  logic [DATA_W-1:0] engine_wdata,
  output logic              engine_gnt,
  output logic              engine_rvalid,
  input  logic              engine_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, HOST, ENG} state_t;
  state_t state, next;
  logic last_eng, full, own_req, oth_req, pick_eng, acc, sel_we;
  logic t1_v, t1_e, t2_v, t2_e;
  logic [7:0] burst_cnt;
  // pick_eng names the candidate; a grant still requires that side's req
  always_comb begin
    own_req = state == HOST ? host_req : engine_req;
    oth_req = state == HOST ? engine_req : host_req;
    full = burst_cnt >= 8'(MAX_BURST);
    if (engine_lock && engine_req) pick_eng = 1'b1;
    else if (state == IDLE) pick_eng = engine_req && (!host_req || !last_eng);
    else pick_eng = (own_req && !(full && oth_req)) ? state == ENG : state == HOST;
    engine_gnt = !reset && engine_req && pick_eng;
    host_gnt = !reset && host_req && !pick_eng;
    acc = host_gnt || engine_gnt;
    sel_we = engine_gnt ? engine_we : host_we;
    next = engine_gnt ? ENG : host_gnt ? HOST : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last_eng <= 1'b0;
      burst_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      t1_v <= 1'b0;
      t1_e <= 1'b0;
      t2_v <= 1'b0;
      t2_e <= 1'b0;
    end else begin
      state <= next;
      if (acc) last_eng <= engine_gnt;
      burst_cnt <= !acc ? 8'd0 : next != state ? 8'd1 : full ? burst_cnt : burst_cnt + 8'd1;
      mem_en <= acc;
      mem_we <= acc && sel_we;
      if (acc) begin
        mem_addr <= engine_gnt ? engine_addr : host_addr;
        mem_wdata <= engine_gnt ? engine_wdata : host_wdata;
      end
      // read tags travel with the access so returns stay ordered across owner switches
      t1_v <= acc && !sel_we;
      t1_e <= engine_gnt;
      t2_v <= t1_v;
      t2_e <= t1_e;
    end
  end
  assign host_rvalid = t2_v && !t2_e;
  assign engine_rvalid = t2_v && t2_e;
  assign rdata = mem_rdata;
`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) stall_cycles <= '0;
    else if (((host_req && !host_gnt) || (engine_req && !engine_gnt)) && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter: randomized scoreboard bench for buffer_arbiter with a rule-level reference model.
module tb_buffer_arbiter;
  localparam int AW = 12, DW = 16, MB = 16;
  logic clock = 0, reset = 1;
  logic host_req = 0, host_we = 0, engine_req = 0, engine_we = 0, engine_lock = 0;
  logic [AW-1:0] host_addr = 0, engine_addr = 0;
  logic [DW-1:0] host_wdata = 0, engine_wdata = 0;
  logic host_gnt, host_rvalid, engine_gnt, engine_rvalid, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;
  logic [DW-1:0] mem_rdata = 0;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cycles;
  int m_stall = 0;
`endif
  always #5 clock = ~clock;
  buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .engine_req(engine_req), .engine_we(engine_we), .engine_addr(engine_addr),
    .engine_wdata(engine_wdata), .engine_gnt(engine_gnt), .engine_rvalid(engine_rvalid),
    .engine_lock(engine_lock), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rdata(rdata)
`ifdef ARB_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  logic [DW-1:0] sram [4096] = '{default: '0};
  always @(posedge clock)
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end
  typedef struct { int due; logic en; logic we; logic [AW-1:0] a; logic [DW-1:0] d; } mexp_t;
  typedef struct { int due; logic eng; logic [DW-1:0] d; } rexp_t;
  mexp_t mq[$];
  rexp_t rq[$];
  int cyc = 0, passed = 0, total = 0;
  int m_owner = 0, m_last = 1, m_run = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wd = 0;
  logic [DW-1:0] shadow [4096] = '{default: '0};
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, got, exp);
  endtask
  // owner codes: 0 none, 1 host, 2 engine
  task automatic step(bit rst, bit hr, bit hw, logic [AW-1:0] ha, logic [DW-1:0] hd,
                      bit er, bit ew, logic [AW-1:0] ea, logic [DW-1:0] ed, bit lk);
    int win;
    bit mine, theirs, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge clock);
    cyc++;
    #1;
    reset = rst; host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    engine_req = er; engine_we = ew; engine_addr = ea; engine_wdata = ed; engine_lock = lk;
    #2;
    if (rst) win = 0;
    else if (lk && er) win = 2;
    else if (m_owner == 0) win = (hr && er) ? (m_last == 2 ? 1 : 2) : hr ? 1 : er ? 2 : 0;
    else begin
      mine = m_owner == 1 ? hr : er;
      theirs = m_owner == 1 ? er : hr;
      win = (mine && !(theirs && m_run == MB)) ? m_owner : theirs ? 3 - m_owner : 0;
    end
    chk("host_gnt", 32'(host_gnt), 32'(win == 1));
    chk("engine_gnt", 32'(engine_gnt), 32'(win == 2));
`ifdef ARB_STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    if (rst) m_stall = 0;
    else if (((hr && win != 1) || (er && win != 2)) && m_stall < 65535) m_stall++;
`endif
    w = 0;
    if (rst) begin
      m_last = 1; m_run = 0; m_addr = 0; m_wd = 0;
      while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
    end else if (win != 0) begin
      w = win == 1 ? hw : ew;
      a = win == 1 ? ha : ea;
      d = win == 1 ? hd : ed;
      m_addr = a; m_wd = d;
      if (w) shadow[a] = d;
      else rq.push_back('{cyc + 2, win == 2, shadow[a]});
      m_run = (win == m_owner) ? (m_run < MB ? m_run + 1 : m_run) : 1;
      m_last = win;
    end
    m_owner = win;
    mq.push_back('{cyc + 1, win != 0, w, m_addr, m_wd});
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial forever begin
    bit exp_h, exp_e;
    mexp_t m;
    rexp_t r;
    @(negedge clock);
    if (mq.size() > 0 && mq[0].due == cyc) begin
      m = mq.pop_front();
      chk("mem_en", 32'(mem_en), 32'(m.en));
      chk("mem_we", 32'(mem_we), 32'(m.we));
      chk("mem_addr", 32'(mem_addr), 32'(m.a));
      chk("mem_wdata", 32'(mem_wdata), 32'(m.d));
    end
    exp_h = rq.size() > 0 && rq[0].due == cyc && !rq[0].eng;
    exp_e = rq.size() > 0 && rq[0].due == cyc && rq[0].eng;
    chk("host_rvalid", 32'(host_rvalid), 32'(exp_h));
    chk("engine_rvalid", 32'(engine_rvalid), 32'(exp_e));
    if (exp_h || exp_e) begin
      r = rq.pop_front();
      chk("rdata", 32'(rdata), 32'(r.d));
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 12'h005, 16'h1234, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 12'h008, 16'hBEEF, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 12'h005, 0, 1, 0, 12'h008, 0, 0);
    idle(3);
    step(0, 1, 1, AW'($urandom), DW'($urandom), 0, 0, 0, 0, 0);
    repeat (40) step(0, 1, 1, AW'($urandom), DW'($urandom), 1, 1, AW'($urandom), DW'($urandom), 0);
    idle(2);
    repeat (3) step(0, 1, 0, AW'($urandom), 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, AW'($urandom), 0, 1, 0, AW'($urandom), 0, 1);
    repeat (2) step(0, 1, 0, AW'($urandom), 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int i = 1; i <= 4; i++) step(0, 1, 1, AW'(i), DW'(16'hA000 + i), 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      if (i % 2 == 1) step(0, 1, 0, AW'(i), 0, 0, 0, 0, 0, 0);
      else step(0, 0, 0, 0, 0, 1, 0, AW'(i), 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 0, 12'h003, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
           $urandom_range(0, 4) == 0);
    idle(4);
    chk("drain", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
